issue_select: RTL and testbench
===============================

# issue_select

Issue-stage consumer for the issue queue: each cycle it inspects the two oldest queue entries, decides in order how many (0–2) can issue, and returns that count as the queue's pop request. Issued entries are registered into two execution-pipe output slots with valid/ready backpressure. A 32-entry register scoreboard, set at issue and cleared at writeback, provides RAW/WAW protection. The block sits between the issue queue and the two execution pipes.

## Interface
Parameters:
- none. Widths come from the shared package: `ISSUE_WIDTH`=2, `REG_ADDR`=5 bits.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  squashes in-flight issue state.
- `iq_size`  in  4  number of valid queue entries.
- `iq_head`  in  `ISSUE_QUEUE_ELEMENT[1:0]`  oldest entries; [0] is the oldest.
- `pop_num`  out  2  entries consumed this cycle (0..2), combinational.
- `wb_en`  in  2  writeback valid, one per pipe.
- `wb_addr`  in  `REG_ADDR[1:0]`  writeback destination registers.
- `exe_ready`  in  2  pipe i accepts `issue_op[i]`.
- `issue_valid`  out  2  output slot i holds an op.
- `issue_op`  out  `ISSUE_QUEUE_ELEMENT[1:0]`  registered issued ops; [0] is older.

## Operation
- `ISSUE_QUEUE_ELEMENT` fields used here: `src0`/`src0_en`, `src1`/`src1_en`, `dst`/`dst_en`, `is_mem`.
- **Scoreboard:** `busy[31:0]`.
  - Issuing an op with `dst_en && dst!=0` sets `busy[dst]`.
  - `wb_en[i] && wb_addr[i]!=0` clears `busy[wb_addr[i]]`.
  - If set and clear hit the same bit in the same cycle, set wins.
  - Register $0 is never busy.
- **Slot free:** slot i is free when `!issue_valid[i] || exe_ready[i]`.
- **Entry 0 issues** when all of the following hold:
  - `iq_size>=1`;
  - every enabled source is not busy;
  - `dst` is not busy (WAW);
  - slot 0 is free.
- **Entry 1 issues** when all of the following hold:
  - entry 0 issues (strict in-order);
  - `iq_size>=2`;
  - its sources and `dst` are not busy;
  - it has no RAW on entry 0's `dst` and no WAW with it (only when entry 0's `dst_en` is set and `dst!=0`);
  - not both entries are `is_mem`;
  - slot 1 is free.
- `pop_num` = number of entries issued: 0, 1 or 2. Entry 1 never issues alone.
- **Output slots:**
  - An issued entry i loads slot i with valid=1.
  - Otherwise, a slot whose op was accepted (`exe_ready`) clears valid.
  - Otherwise, the slot holds its value.
- **Flush:**
  - Forces `pop_num`=0.
  - Clears `issue_valid` and all of `busy` at the next edge.
  - Writebacks in the flush cycle are ignored.
- **Reset:**
  - `issue_valid`=0, `issue_op`=0, `busy`=0.
  - `pop_num`=0 while `rst` is high.

## Timing
- `pop_num` is combinational from `iq_size`, `iq_head`, `busy`, `wb_*`, `exe_ready`, `flush` and `rst`. The queue advances its read pointer at the same edge.
- Issue latency: an entry poppable in cycle N appears on `issue_op` in cycle N+1.
- A busy bit set at edge N blocks dependents from cycle N+1. A dependent issues no earlier than the writeback cycle (with bypass) or the cycle after it (without).
- Back-to-back issue into the same slot is allowed when `exe_ready` is high. Full throughput is 2 ops/cycle.
- When `iq_size` is 0 or 1, entries beyond the size are ignored regardless of their contents.

## Configuration
- `ISSUE_WB_BYPASS_EN` defined: a busy source or dst being cleared by `wb_en`/`wb_addr` in the current cycle counts as ready in that same cycle.
- `ISSUE_WB_BYPASS_EN` undefined: readiness uses the registered `busy` only, so dependents wait one extra cycle after writeback.

## Structure
- Shared package holds:
  - `ISSUE_QUEUE_ELEMENT`;
  - `REG_ADDR`;
  - `ISSUE_WIDTH`;
  - the nop constant used as the reset/flush value of `issue_op`.
- One sub-module, `reg_scoreboard`:
  - 2 set ports, 2 clear ports, flush, and the busy vector;
  - set-over-clear priority;
  - $0 masking.
- `issue_select` holds the pair-check logic, `pop_num` generation and the output slots.

## Test plan
- **Reset:** drive `rst` for 2 cycles with `iq_size`=4 → `pop_num`=0; afterwards `issue_valid`=00 and `busy`=0.
- **Independent dual issue:** head0 `dst`=3, head1 `dst`=4 (no sources), `exe_ready`=11 → `pop_num`=2; next cycle `issue_valid`=11 and `busy[3]` and `busy[4]` set.
- **Intra-pair RAW:** head0 `dst`=5, head1 `src0`=5 → `pop_num`=1; head1 stays until `wb_addr`=5. With bypass it issues in the writeback cycle; without bypass, one cycle later.
- **Both memory ops:** head0 and head1 both `is_mem` → `pop_num`=1; the next cycle the second one issues alone.
- **Backpressure:** `issue_valid[0]`=1 and `exe_ready[0]`=0 → `pop_num`=0 and `issue_op[0]` is held. Raising `exe_ready` allows `pop_num` of 1 or 2 in that same cycle.
- **Flush:** flush asserted with `busy[7]` set, both slots valid, and `wb_en`=01 → `pop_num`=0 and, at the next edge, `issue_valid`=00 and `busy`=0.

Source files
------------

// File: rtl/issue_select_pkg.sv
// Shared types for the issue-select stage: queue element, register width,
// issue width, the nop used to reset issue slots, and a register-mask helper.
package issue_select_pkg;

  localparam int ISSUE_WIDTH = 2;
  localparam int REG_ADDR    = 5;

  typedef logic [REG_ADDR-1:0] reg_addr_t;

  typedef struct packed {
    logic [7:0] uop;
    reg_addr_t  src0;
    logic       src0_en;
    reg_addr_t  src1;
    logic       src1_en;
    reg_addr_t  dst;
    logic       dst_en;
    logic       is_mem;
  } ISSUE_QUEUE_ELEMENT;

  localparam ISSUE_QUEUE_ELEMENT ISSUE_NOP = '0;

  // One-hot register bit, empty for disabled ops and for $0.
  function automatic logic [31:0] reg_mask(input logic en,
                                           input reg_addr_t a);
    return (en && a != '0) ? (32'd1 << a) : 32'd0;
  endfunction

endpackage

// File: rtl/issue_select_if.sv
// Issue-queue / writeback / execution-pipe bundle for issue_select.
// slave: issue_select side; master: queue and pipe side.
interface issue_select_if;
  import issue_select_pkg::*;

  logic [3:0]                           iq_size;
  ISSUE_QUEUE_ELEMENT [ISSUE_WIDTH-1:0] iq_head;
  logic [1:0]                           pop_num;
  logic [ISSUE_WIDTH-1:0]               wb_en;
  reg_addr_t [ISSUE_WIDTH-1:0]          wb_addr;
  logic [ISSUE_WIDTH-1:0]               exe_ready;
  logic [ISSUE_WIDTH-1:0]               issue_valid;
  ISSUE_QUEUE_ELEMENT [ISSUE_WIDTH-1:0] issue_op;

  modport master (
    output iq_size, iq_head, wb_en, wb_addr, exe_ready,
    input  pop_num, issue_valid, issue_op
  );

  modport slave (
    input  iq_size, iq_head, wb_en, wb_addr, exe_ready,
    output pop_num, issue_valid, issue_op
  );

endinterface

// File: rtl/issue_select_reg_scoreboard.sv
// 32-entry busy scoreboard: set at issue, cleared at writeback, set wins.
// Ports: clk, rst, flush, set_en/set_addr, clr_en/clr_addr, busy.
module reg_scoreboard
  import issue_select_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [ISSUE_WIDTH-1:0]       set_en,
  input  reg_addr_t [ISSUE_WIDTH-1:0]  set_addr,
  input  logic [ISSUE_WIDTH-1:0]       clr_en,
  input  reg_addr_t [ISSUE_WIDTH-1:0]  clr_addr,
  output logic [31:0]                  busy
);

  logic [31:0] set_m;
  logic [31:0] clr_m;
  logic [31:0] busy_n;

  always_comb begin
    set_m = '0;
    clr_m = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      set_m = set_m | reg_mask(set_en[i], set_addr[i]);
      clr_m = clr_m | reg_mask(clr_en[i], clr_addr[i]);
    end
    busy_n    = (busy & ~clr_m) | set_m;
    busy_n[0] = 1'b0;
  end

  // Flush drops every pending writeback along with the busy state.
  always_ff @(posedge clk) begin
    if (rst || flush) busy <= '0;
    else              busy <= busy_n;
  end

endmodule

// File: rtl/issue_select.sv
// In-order dual issue select with scoreboard and two registered output slots.
// Ports: clk, rst, flush, bus (issue_select_if.slave). Option: ISSUE_WB_BYPASS_EN.
module issue_select
  import issue_select_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  issue_select_if.slave bus
);

  ISSUE_QUEUE_ELEMENT h0;
  ISSUE_QUEUE_ELEMENT h1;
  logic [31:0]        busy;
  logic [31:0]        busy_eff;
  logic [1:0]         slot_free;
  logic [1:0]         iss;
  logic [1:0]         set_en;
  logic               dep;
  logic [1:0]         valid_q;
  ISSUE_QUEUE_ELEMENT [1:0] op_q;

  assign h0 = bus.iq_head[0];
  assign h1 = bus.iq_head[1];

`ifdef ISSUE_WB_BYPASS_EN
  // A register written back this cycle is already readable.
  logic [31:0] wb_clr;
  assign wb_clr = reg_mask(bus.wb_en[0], bus.wb_addr[0])
                | reg_mask(bus.wb_en[1], bus.wb_addr[1]);
  assign busy_eff = busy & ~wb_clr;
`else
  assign busy_eff = busy;
`endif

  function automatic logic ops_ready(input ISSUE_QUEUE_ELEMENT e,
                                     input logic [31:0] b);
    return (!e.src0_en || !b[e.src0])
        && (!e.src1_en || !b[e.src1])
        && (!e.dst_en  || !b[e.dst]);
  endfunction

  assign slot_free = ~valid_q | bus.exe_ready;

  // Entry 1 depends on entry 0 through RAW or WAW on entry 0's dst.
  assign dep = h0.dst_en && h0.dst != '0
            && ((h1.src0_en && h1.src0 == h0.dst)
             || (h1.src1_en && h1.src1 == h0.dst)
             || (h1.dst_en  && h1.dst  == h0.dst));

  assign iss[0] = !rst && !flush
               && bus.iq_size >= 4'd1
               && ops_ready(h0, busy_eff)
               && slot_free[0];

  assign iss[1] = iss[0]
               && bus.iq_size >= 4'd2
               && ops_ready(h1, busy_eff)
               && !dep
               && !(h0.is_mem && h1.is_mem)
               && slot_free[1];

  assign bus.pop_num = {1'b0, iss[0]} + {1'b0, iss[1]};

  assign set_en = {iss[1] && h1.dst_en, iss[0] && h0.dst_en};

  reg_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .set_en   (set_en),
    .set_addr ({h1.dst, h0.dst}),
    .clr_en   (bus.wb_en),
    .clr_addr (bus.wb_addr),
    .busy     (busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      op_q    <= {ISSUE_NOP, ISSUE_NOP};
    end else if (flush) begin
      valid_q <= '0;
      op_q    <= {ISSUE_NOP, ISSUE_NOP};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (iss[i]) begin
          valid_q[i] <= 1'b1;
          op_q[i]    <= bus.iq_head[i];
        end else if (bus.exe_ready[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.issue_valid = valid_q;
  assign bus.issue_op    = op_q;

endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select: pop_num and state checked per cycle,
// issued ops checked by a monitor against per-slot expectation queues.
module tb_issue_select;
  import issue_select_pkg::*;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;

  ISSUE_QUEUE_ELEMENT q0[$];
  ISSUE_QUEUE_ELEMENT q1[$];

  issue_select_if bus ();

  issue_select dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ISSUE_QUEUE_ELEMENT mk(
    input logic [7:0] u,
    input logic [4:0] s0, input logic s0e,
    input logic [4:0] s1, input logic s1e,
    input logic [4:0] d,  input logic de,
    input logic       m);
    ISSUE_QUEUE_ELEMENT e;
    e.uop = u;
    e.src0 = s0; e.src0_en = s0e;
    e.src1 = s1; e.src1_en = s1e;
    e.dst  = d;  e.dst_en  = de;
    e.is_mem = m;
    return e;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Accepted ops leave the slot at the next edge; compare in issue order.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst && bus.issue_valid[i] === 1'b1
          && bus.exe_ready[i] === 1'b1) begin
        ISSUE_QUEUE_ELEMENT e;
        if (i == 0) begin
          if (q0.size() == 0) e = ISSUE_NOP;
          else e = q0.pop_front();
        end else begin
          if (q1.size() == 0) e = ISSUE_NOP;
          else e = q1.pop_front();
        end
        chk(i == 0 ? "mon slot0" : "mon slot1",
            64'(bus.issue_op[i]), 64'(e));
      end
    end
  end

  task automatic cyc(input string name,
                     input logic r, input logic fl,
                     input logic [3:0] sz,
                     input ISSUE_QUEUE_ELEMENT a,
                     input ISSUE_QUEUE_ELEMENT b,
                     input logic [1:0] we,
                     input logic [4:0] w0, input logic [4:0] w1,
                     input logic [1:0] rdy,
                     input logic [1:0] ep);
    @(posedge clk);
    #1;
    rst = r;
    flush = fl;
    bus.iq_size = sz;
    bus.iq_head[0] = a;
    bus.iq_head[1] = b;
    bus.wb_en = we;
    bus.wb_addr[0] = w0;
    bus.wb_addr[1] = w1;
    bus.exe_ready = rdy;
    @(negedge clk);
    chk(name, 64'(bus.pop_num), 64'(ep));
    if (ep >= 2'd1) q0.push_back(a);
    if (ep == 2'd2) q1.push_back(b);
  endtask

  ISSUE_QUEUE_ELEMENT A, B, C, D, E, F, G, H, J, K, L, M, N, O, Z;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    flush = 1'b0;
    bus.iq_size = '0;
    bus.iq_head = '0;
    bus.wb_en = '0;
    bus.wb_addr = '0;
    bus.exe_ready = '0;

    Z = ISSUE_NOP;
    A = mk(8'h0a, 0, 0, 0, 0, 3, 1, 0);
    B = mk(8'h0b, 0, 0, 0, 0, 4, 1, 0);
    C = mk(8'h0c, 0, 0, 0, 0, 5, 1, 0);
    D = mk(8'h0d, 5, 1, 0, 0, 6, 1, 0);
    E = mk(8'h0e, 0, 0, 0, 0, 7, 1, 1);
    F = mk(8'h0f, 0, 0, 0, 0, 8, 1, 1);
    G = mk(8'h10, 0, 0, 0, 0, 9, 1, 0);
    H = mk(8'h11, 1, 1, 0, 0, 9, 1, 0);
    J = mk(8'h12, 2, 1, 0, 0, 0, 1, 1);
    K = mk(8'h13, 1, 1, 2, 1, 0, 0, 0);
    L = mk(8'h14, 0, 0, 3, 1, 0, 0, 1);
    M = mk(8'h15, 0, 0, 0, 0, 7, 1, 0);
    N = mk(8'h16, 0, 0, 0, 0, 0, 0, 0);
    O = mk(8'h17, 4, 1, 0, 0, 0, 0, 0);

    cyc("rst pop 0", 1, 0, 4, A, B, 0, 0, 0, 3, 0);
    cyc("rst pop 1", 1, 0, 4, A, B, 0, 0, 0, 3, 0);
    cyc("empty pop", 0, 0, 0, A, B, 0, 0, 0, 3, 0);
    chk("rst valid", 64'(bus.issue_valid), 64'(0));
    chk("rst busy", 64'(dut.busy), 64'(0));

    cyc("dual pop", 0, 0, 2, A, B, 0, 0, 0, 3, 2);
    cyc("idle pop", 0, 0, 0, Z, Z, 0, 0, 0, 3, 0);
    chk("dual valid", 64'(bus.issue_valid), 64'(2'b11));
    chk("dual busy", 64'(dut.busy), 64'(32'h18));
    cyc("wb34 pop", 0, 0, 0, Z, Z, 2'b11, 3, 4, 3, 0);

    cyc("raw pair", 0, 0, 2, C, D, 0, 0, 0, 3, 1);
    cyc("raw wait", 0, 0, 1, D, A, 0, 0, 0, 3, 0);
    chk("raw busy", 64'(dut.busy), 64'(32'h20));
`ifdef ISSUE_WB_BYPASS_EN
    cyc("raw wb", 0, 0, 1, D, A, 2'b01, 5, 0, 3, 1);
    cyc("raw after", 0, 0, 0, Z, Z, 0, 0, 0, 3, 0);
`else
    cyc("raw wb", 0, 0, 1, D, A, 2'b01, 5, 0, 3, 0);
    cyc("raw after", 0, 0, 1, D, A, 0, 0, 0, 3, 1);
`endif
    cyc("wb6", 0, 0, 0, Z, Z, 2'b10, 0, 6, 3, 0);

    cyc("mem pair", 0, 0, 2, E, F, 0, 0, 0, 3, 1);
    chk("mem busy", 64'(dut.busy), 64'(0));
    cyc("mem 2nd", 0, 0, 1, F, G, 0, 0, 0, 3, 1);
    cyc("waw pair", 0, 0, 2, G, H, 2'b11, 7, 8, 3, 1);
    cyc("wb9", 0, 0, 0, Z, Z, 2'b01, 9, 0, 3, 0);
    cyc("waw 2nd", 0, 0, 1, H, J, 0, 0, 0, 3, 1);

    cyc("size1", 0, 0, 1, J, K, 2'b01, 9, 0, 3, 1);
    cyc("bp stall", 0, 0, 2, K, L, 0, 0, 0, 0, 0);
    chk("bp hold op", 64'(bus.issue_op[0]), 64'(J));
    chk("dst0 busy", 64'(dut.busy), 64'(0));
    cyc("bp stall2", 0, 0, 2, K, L, 0, 0, 0, 0, 0);
    chk("bp valid", 64'(bus.issue_valid), 64'(2'b01));
    chk("bp hold2", 64'(bus.issue_op[0]), 64'(J));
    cyc("bp release", 0, 0, 2, K, L, 0, 0, 0, 3, 2);

    cyc("pre flush", 0, 0, 1, M, N, 0, 0, 0, 3, 1);
    cyc("fill slots", 0, 0, 2, N, O, 0, 0, 0, 3, 2);
    chk("fl busy7", 64'(dut.busy), 64'(32'h80));
    cyc("flush pop", 0, 1, 2, A, B, 2'b01, 7, 0, 0, 0);
    chk("fl valid pre", 64'(bus.issue_valid), 64'(2'b11));
    q0.delete();
    q1.delete();
    cyc("post flush", 0, 0, 0, Z, Z, 0, 0, 0, 3, 0);
    chk("fl valid", 64'(bus.issue_valid), 64'(0));
    chk("fl busy", 64'(dut.busy), 64'(0));

    @(negedge clk);
    chk("queues drained", 64'(q0.size() + q1.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
